// File: rtl/interrupt_unit_pkg.sv
// Shared constants and helpers for the interrupt front-end of the status counter.
package interrupt_unit_pkg;

  localparam int unsigned N_IRQ_DEFAULT       = 4;
  localparam int unsigned N_IRQ_MAX           = 8;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  // Every source starts enabled; the global enable starts off.
  localparam logic [N_IRQ_MAX-1:0] MASK_RESET = '1;
  localparam logic                 IE_RESET   = 1'b0;

  // Width of the vector output, never narrower than one bit.
  function automatic int unsigned vec_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Fixed-priority encoder: index of the lowest set bit, 0 when none is set.
  function automatic logic [2:0] lowest_set(input logic [N_IRQ_MAX-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = int'(N_IRQ_MAX) - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_unit_if.sv
// Request/acknowledge bundle between the interrupt unit and its environment.
interface interrupt_unit_if #(
  parameter int unsigned N_IRQ = interrupt_unit_pkg::N_IRQ_DEFAULT
);
  import interrupt_unit_pkg::*;

  localparam int unsigned VW = vec_width(N_IRQ);

  // Environment to unit
  logic [N_IRQ-1:0] irq_in;
  logic             ie_set;
  logic             ie_clr;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_wdata;
  logic             IT0;
  logic             IT2;

  // Unit to environment
  logic             ITA;
  logic [VW-1:0]    VEC;
  logic             IE;
  logic [N_IRQ-1:0] PEND;
  logic             IN_SVC;

  // Environment side: external lines, software strobes and status-counter states.
  modport master (
    output irq_in, ie_set, ie_clr, mask_we, mask_wdata, IT0, IT2,
    input  ITA, VEC, IE, PEND, IN_SVC
  );

  // Interrupt unit side.
  modport slave (
    input  irq_in, ie_set, ie_clr, mask_we, mask_wdata, IT0, IT2,
    output ITA, VEC, IE, PEND, IN_SVC
  );

endinterface

// File: rtl/interrupt_unit_irq_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line followed by a rising-edge detector.
module irq_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the line through the synchronizer and remember the last synchronized value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // One-cycle pulse when the synchronized line goes 0 -> 1.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/interrupt_unit.sv
// Interrupt front-end: latches synchronized rising edges as pending requests, masks them,
// raises ITA toward the status counter and commits the captured candidate on IT0.
module interrupt_unit
  import interrupt_unit_pkg::*;
#(
  parameter int unsigned N_IRQ       = N_IRQ_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  interrupt_unit_if.slave bus
);

  localparam int unsigned VW = vec_width(N_IRQ);

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] commit_clr;
  logic [VW-1:0]    cand;

  logic [N_IRQ-1:0] pend_q,   pend_d;
  logic [N_IRQ-1:0] mask_q,   mask_d;
  logic             ie_q,     ie_d;
  logic             ita_q,    ita_d;
  logic [VW-1:0]    cand_q,   cand_d;
  logic [VW-1:0]    vec_q,    vec_d;
  logic             in_svc_q, in_svc_d;

  // One synchronizer/edge detector per source.
  for (genvar i = 0; i < int'(N_IRQ); i++) begin : g_sync
    irq_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (bus.irq_in[i]),
      .rise     (rise[i])
    );
  end

  // Next-state logic for all unit registers.
  always_comb begin
    elig       = pend_q & mask_q;
    cand       = VW'(lowest_set(N_IRQ_MAX'(elig)));
    commit_clr = '0;
    pend_d     = pend_q;
    mask_d     = mask_q;
    ie_d       = ie_q;
    ita_d      = 1'b0;
    cand_d     = cand_q;
    vec_d      = vec_q;
    in_svc_d   = in_svc_q;

    // Commit clears the source captured with ITA; a fresh edge on it still wins.
    if (bus.IT0) begin
      commit_clr = N_IRQ'(1) << cand_q;
      vec_d      = cand_q;
    end
    pend_d = (pend_q & ~commit_clr) | rise;

    if (bus.mask_we) mask_d = bus.mask_wdata;

    // Clear beats set, and acceptance always drops the enable.
    if (bus.ie_set)            ie_d = 1'b1;
    if (bus.ie_clr || bus.IT0) ie_d = 1'b0;

    ita_d = (|elig) & ie_q & ~bus.IT0 & ~in_svc_q;
    if (ita_d) cand_d = cand;

    if (bus.IT0)      in_svc_d = 1'b1;
    else if (bus.IT2) in_svc_d = 1'b0;
  end

  // Unit state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q   <= '0;
      mask_q   <= MASK_RESET[N_IRQ-1:0];
      ie_q     <= IE_RESET;
      ita_q    <= 1'b0;
      cand_q   <= '0;
      vec_q    <= '0;
      in_svc_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      ie_q     <= ie_d;
      ita_q    <= ita_d;
      cand_q   <= cand_d;
      vec_q    <= vec_d;
      in_svc_q <= in_svc_d;
    end
  end

  assign bus.ITA    = ita_q;
  assign bus.VEC    = vec_q;
  assign bus.IE     = ie_q;
  assign bus.PEND   = pend_q;
  assign bus.IN_SVC = in_svc_q;

endmodule

// File: tb/tb_interrupt_unit.sv
// Bench for interrupt_unit: directed scenarios then random traffic, each cycle's expected
// outputs queued by the stimulus side and checked by an independent negedge monitor.
module tb_interrupt_unit;

  localparam int unsigned N  = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned VW = $clog2(N);

  typedef struct {
    logic [N-1:0] irq;
    bit           ies;
    bit           iec;
    bit           mwe;
    logic [N-1:0] mwd;
    bit           it0;
    bit           it2;
    bit           rst;
  } stim_t;

  typedef struct {
    logic          ita;
    logic [VW-1:0] vec;
    logic          ie;
    logic [N-1:0]  pend;
    logic          insvc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  interrupt_unit_if #(.N_IRQ(N)) bus ();

  interrupt_unit #(
    .N_IRQ       (N),
    .SYNC_STAGES (D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  stim_t st;
  stim_t cur;
  exp_t  sb[$];
  int    nvec = 0;
  int    nmis = 0;

  // Reference model state
  logic [N-1:0] m_pend;
  logic [N-1:0] m_mask;
  bit           m_ie;
  bit           m_ita;
  int           m_cand;
  int           m_vec;
  bit           m_insvc;
  logic [N-1:0] hist[$];   // samples of irq_in taken at each edge, newest first

  function automatic void model_reset();
    m_pend  = '0;
    m_mask  = '1;
    m_ie    = 1'b0;
    m_ita   = 1'b0;
    m_cand  = 0;
    m_vec   = 0;
    m_insvc = 1'b0;
    hist.delete();
    for (int i = 0; i < int'(D) + 2; i++) hist.push_front('0);
  endfunction

  // One clock edge with the inputs in 'cur'.
  function automatic void model_edge();
    logic [N-1:0] rose;
    logic [N-1:0] elig;
    logic [N-1:0] pend_n;
    bit           ita_n;
    int           first;
    if (cur.rst) begin
      model_reset();
      return;
    end
    hist.push_front(cur.irq);
    void'(hist.pop_back());
    // A line is recognised D edges after the edge at which it was first seen high.
    rose  = hist[D] & ~hist[D+1];
    elig  = m_pend & m_mask;
    first = -1;
    for (int i = int'(N) - 1; i >= 0; i--) if (elig[i]) first = i;
    pend_n = m_pend;
    if (cur.it0) begin
      pend_n[m_cand] = 1'b0;
      m_vec          = m_cand;
    end
    pend_n = pend_n | rose;
    ita_n  = (first >= 0) && m_ie && !cur.it0 && !m_insvc;
    if (ita_n) m_cand = first;
    if (cur.iec || cur.it0) m_ie = 1'b0;
    else if (cur.ies)       m_ie = 1'b1;
    if (cur.it0)      m_insvc = 1'b1;
    else if (cur.it2) m_insvc = 1'b0;
    if (cur.mwe) m_mask = cur.mwd;
    m_pend = pend_n;
    m_ita  = ita_n;
  endfunction

  task automatic drive();
    reset          = cur.rst;
    bus.irq_in     = cur.irq;
    bus.ie_set     = cur.ies;
    bus.ie_clr     = cur.iec;
    bus.mask_we    = cur.mwe;
    bus.mask_wdata = cur.mwd;
    bus.IT0        = cur.it0;
    bus.IT2        = cur.it2;
  endtask

  // Advance one cycle: model the edge, apply 'st', queue the expected outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    cur = st;
    drive();
    if (cur.rst) model_reset();
    e.ita   = m_ita;
    e.vec   = VW'(m_vec);
    e.ie    = m_ie;
    e.pend  = m_pend;
    e.insvc = m_insvc;
    sb.push_back(e);
    st.ies = 1'b0;
    st.iec = 1'b0;
    st.mwe = 1'b0;
    st.it0 = 1'b0;
    st.it2 = 1'b0;
  endtask

  task automatic wait_ita(input int limit);
    int n;
    n = 0;
    while (!m_ita && n < limit) begin
      tick();
      n++;
    end
    if (!m_ita) begin
      nvec++;
      nmis++;
      $display("FAIL wait_ita: request not raised within %0d cycles, required ITA=1", limit);
    end
  endtask

  task automatic service(input int len);
    st.it0 = 1'b1;
    tick();
    repeat (len) tick();
    st.it2 = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: compares one queued expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        nvec++;
        if (bus.ITA !== e.ita || bus.VEC !== e.vec || bus.IE !== e.ie ||
            bus.PEND !== e.pend || bus.IN_SVC !== e.insvc) begin
          nmis++;
          $display("FAIL outputs @%0t: got ITA=%b VEC=%0d IE=%b PEND=%b IN_SVC=%b, expected ITA=%b VEC=%0d IE=%b PEND=%b IN_SVC=%b",
                   $time, bus.ITA, bus.VEC, bus.IE, bus.PEND, bus.IN_SVC,
                   e.ita, e.vec, e.ie, e.pend, e.insvc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ctl_busy;
    int svc_left;
    st       = '{default: '0};
    st.rst   = 1'b1;
    cur      = st;
    drive();
    model_reset();

    // Reset, release with quiet lines, enable
    repeat (3) tick();
    st.rst = 1'b0;
    tick();
    st.ies = 1'b1;
    tick();
    repeat (2) tick();

    // Single source 2 through a full IT0..IT2 service
    st.irq = 4'b0100;
    wait_ita(8);
    service(2);
    st.irq = 4'b0000;
    repeat (3) tick();

    // Sources 1 and 3 together: 1 first, 3 after re-enable
    st.irq = 4'b1010;
    st.ies = 1'b1;
    tick();
    wait_ita(8);
    service(1);
    st.ies = 1'b1;
    tick();
    wait_ita(8);
    service(1);
    st.irq = 4'b0000;
    repeat (3) tick();

    // Masked source stays pending, unmasking raises the request
    st.mwe = 1'b1;
    st.mwd = 4'b1110;
    st.ies = 1'b1;
    tick();
    st.irq = 4'b0001;
    repeat (5) tick();
    st.mwe = 1'b1;
    st.mwd = 4'b1111;
    tick();
    wait_ita(4);
    service(1);
    st.irq = 4'b0000;
    tick();

    // ie_clr together with IT0 still commits; set and clear together leaves IE low
    st.ies = 1'b1;
    st.irq = 4'b0100;
    tick();
    wait_ita(8);
    st.iec = 1'b1;
    st.it0 = 1'b1;
    tick();
    tick();
    st.it2 = 1'b1;
    tick();
    st.ies = 1'b1;
    st.iec = 1'b1;
    tick();
    tick();

    // New edge on source 1 coincides with its own commit, then reset mid-service
    st.irq = 4'b0000;
    st.ies = 1'b1;
    repeat (3) tick();
    st.irq = 4'b0010;
    tick();
    st.irq = 4'b0000;
    tick();
    tick();
    st.irq = 4'b0010;
    tick();
    tick();
    st.it0 = 1'b1;
    tick();
    tick();
    st.rst = 1'b1;
    tick();
    tick();
    st.rst = 1'b0;
    st.irq = 4'b0000;
    repeat (3) tick();

    // Random traffic with a status-counter stand-in that accepts ITA
    ctl_busy = 1'b0;
    svc_left = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < int'(N); i++) begin
        if ($urandom_range(0, 9) == 0) st.irq[i] = ~st.irq[i];
      end
      st.ies = ($urandom_range(0, 5) == 0);
      st.iec = ($urandom_range(0, 24) == 0);
      st.mwe = ($urandom_range(0, 39) == 0);
      st.mwd = N'($urandom);
      if (st.rst) st.rst = ($urandom_range(0, 1) == 0);
      else        st.rst = ($urandom_range(0, 399) == 0);
      if (st.rst) begin
        ctl_busy = 1'b0;
      end else if (!ctl_busy) begin
        if (m_ita && $urandom_range(0, 3) != 0) begin
          st.it0   = 1'b1;
          ctl_busy = 1'b1;
          svc_left = $urandom_range(0, 3);
        end
      end else if (svc_left == 0) begin
        st.it2   = 1'b1;
        ctl_busy = 1'b0;
      end else begin
        svc_left--;
      end
      tick();
    end

    st     = '{default: '0};
    repeat (2) tick();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      nvec++;
      nmis++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
